motor_toggle_debouncer: RTL and testbench

- Producer side of the LED/motor-state interface: turns a raw, bouncing push-button into a debounced toggle state `dbstate` plus a one-cycle `enable` strobe.
- The LED driver and motor controller sample `dbstate` on any clock edge where `enable` is high.
- Includes an emergency-stop override that forces the state off.
- Sits between the board button pin and the LED/motor consumers.

---
 rtl/motor_ctrl_pkg.sv | 16 +
 rtl/sync_2ff.sv | 28 ++
 rtl/motor_toggle_debouncer.sv | 120 ++++++++++++
 tb/tb_motor_toggle_debouncer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the button/LED/motor control slice.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CNT,
        PRESSED,
        RELEASE_CNT
    } dbnc_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit flop-chain synchronizer for asynchronous board inputs; clears to 0 on reset.
module sync_2ff
    import motor_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/motor_toggle_debouncer.sv
// Debounces a raw push-button into a toggle state with a one-cycle update strobe
// and an emergency-stop override that forces the state off.
module motor_toggle_debouncer
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic estop,
    output logic dbstate,
    output logic enable,
    output logic btn_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter already holds the samples seen before this edge, so the
    // current sample completes the run when the count reaches DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic btn_s;

    sync_2ff u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (btn_s)
    );

    dbnc_state_t      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             toggle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_CNT;
                    cnt_d   = CntOne;
                end
            end
            PRESS_CNT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= CntLast) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    toggle  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_CNT;
                    cnt_d   = CntOne;
                end
            end
            RELEASE_CNT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CntLast) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // tgt_q is the state the consumers should end up with; dbstate follows it but
    // never changes on the cycle right after a strobe, so enable cannot repeat.
    logic tgt_d, tgt_q;
    logic dbstate_d, dbstate_q;
    logic enable_d, enable_q;

    always_comb begin
        tgt_d = tgt_q;
        if (estop) begin
            tgt_d = LED_OFF;
        end else if (toggle) begin
            tgt_d = (tgt_q == LED_ON) ? LED_OFF : LED_ON;
        end
        dbstate_d = enable_q ? dbstate_q : tgt_d;
        enable_d  = (dbstate_d != dbstate_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            tgt_q     <= LED_OFF;
            dbstate_q <= LED_OFF;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            dbstate_q <= dbstate_d;
            enable_q  <= enable_d;
        end
    end

    assign dbstate   = dbstate_q;
    assign enable    = enable_q;
    assign btn_level = (state_q == PRESSED) || (state_q == RELEASE_CNT);

endmodule

// File: tb/tb_motor_toggle_debouncer.sv
// Directed bench for motor_toggle_debouncer with DEBOUNCE_CYCLES = 4.
module tb_motor_toggle_debouncer;

    localparam int unsigned DBC = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic estop;
    logic dbstate;
    logic enable;
    logic btn_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    motor_toggle_debouncer #(
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .estop     (estop),
        .dbstate   (dbstate),
        .enable    (enable),
        .btn_level (btn_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (enable) pulses++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 1'b0;
        estop   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int p;
        int q;
        int lvl;
        logic [5:0] pat;
        pat = 6'b010101;

        // Reset, then a clean press: strobe on the 6th edge after btn_raw rises.
        rst = 1'b1; btn_raw = 1'b0; estop = 1'b0;
        repeat (3) tick();
        check_eq("rst_dbstate", 32'(dbstate), 0);
        check_eq("rst_enable", 32'(enable), 0);
        check_eq("rst_level", 32'(btn_level), 0);
        rst = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("press_early_enable", 32'(enable), 0);
        end
        tick();
        check_eq("press_enable", 32'(enable), 1);
        check_eq("press_dbstate", 32'(dbstate), 1);
        check_eq("press_level", 32'(btn_level), 1);
        run(50, p);
        check_eq("held_no_retoggle", 32'(p), 0);
        check_eq("held_dbstate", 32'(dbstate), 1);

        // Bounce rejection.
        do_reset();
        check_eq("rst2_dbstate", 32'(dbstate), 0);
        p = 0; lvl = 0;
        for (int i = 0; i < 14; i++) begin
            btn_raw = (i < 6) ? pat[i] : 1'b0;
            tick();
            if (enable) p++;
            if (btn_level) lvl++;
        end
        check_eq("bounce_pulses", 32'(p), 0);
        check_eq("bounce_level", 32'(lvl), 0);
        check_eq("bounce_dbstate", 32'(dbstate), 0);

        // Bouncy press then stable, release, second press.
        p = 0;
        for (int i = 0; i < 6; i++) begin
            btn_raw = pat[i];
            tick();
            if (enable) p++;
        end
        btn_raw = 1'b1;
        run(12, q);
        check_eq("bouncy_press_pulses", 32'(p + q), 1);
        check_eq("bouncy_press_dbstate", 32'(dbstate), 1);
        check_eq("bouncy_press_level", 32'(btn_level), 1);
        btn_raw = 1'b0;
        repeat (5) tick();
        check_eq("release_level_held", 32'(btn_level), 1);
        tick();
        check_eq("release_level_drop", 32'(btn_level), 0);
        check_eq("release_dbstate", 32'(dbstate), 1);
        btn_raw = 1'b1;
        run(12, p);
        check_eq("second_press_pulses", 32'(p), 1);
        check_eq("second_press_dbstate", 32'(dbstate), 0);
        btn_raw = 1'b0;
        run(8, p);
        check_eq("second_release_pulses", 32'(p), 0);

        // estop with the motor on.
        btn_raw = 1'b1;
        run(12, p);
        check_eq("estop_pre_pulses", 32'(p), 1);
        check_eq("estop_pre_dbstate", 32'(dbstate), 1);
        btn_raw = 1'b0;
        run(8, p);
        estop = 1'b1;
        tick();
        check_eq("estop_first_enable", 32'(enable), 1);
        check_eq("estop_first_dbstate", 32'(dbstate), 0);
        btn_raw = 1'b1;
        run(9, p);
        check_eq("estop_press_pulses", 32'(p), 0);
        check_eq("estop_press_dbstate", 32'(dbstate), 0);
        check_eq("estop_press_level", 32'(btn_level), 1);
        estop = 1'b0;
        run(10, p);
        check_eq("estop_after_pulses", 32'(p), 0);
        check_eq("estop_after_dbstate", 32'(dbstate), 0);
        btn_raw = 1'b0;
        run(8, p);

        // estop arrives on the same edge the press is accepted, dbstate = 0.
        btn_raw = 1'b1;
        repeat (5) tick();
        check_eq("simul_pre_enable", 32'(enable), 0);
        estop = 1'b1;
        tick();
        check_eq("simul_dbstate", 32'(dbstate), 0);
        check_eq("simul_enable", 32'(enable), 0);
        check_eq("simul_level", 32'(btn_level), 1);
        estop = 1'b0;
        run(5, p);
        check_eq("simul_after_pulses", 32'(p), 0);
        check_eq("simul_after_dbstate", 32'(dbstate), 0);
        btn_raw = 1'b0;
        run(8, p);

        // Reset in the middle of a count restarts from the synchronizer.
        btn_raw = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rstmid_early_enable", 32'(enable), 0);
        end
        tick();
        check_eq("rstmid_enable", 32'(enable), 1);
        check_eq("rstmid_dbstate", 32'(dbstate), 1);

        // estop on the cycle right after a toggle: the off strobe is delayed one cycle.
        do_reset();
        btn_raw = 1'b1;
        repeat (6) tick();
        check_eq("gap_toggle_enable", 32'(enable), 1);
        estop = 1'b1;
        tick();
        check_eq("gap_no_back_to_back", 32'(enable), 0);
        tick();
        check_eq("gap_off_enable", 32'(enable), 1);
        check_eq("gap_off_dbstate", 32'(dbstate), 0);
        estop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
